// File: rtl/mic3_pkg.sv
// Shared constants, state encoding and frame-building helper for the MIC3 ADC responder.
package mic3_pkg;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 3;
  localparam int DATA_BITS  = 12;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TRAIL = 2'd2
  } state_e;

  // Frame word: leading zeros, conversion data MSB first, one trailing zero.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] d);
    return {{LEAD_ZEROS{1'b0}}, d, 1'b0};
  endfunction

endpackage

// File: rtl/mic3_responder_sync_edge.sv
// N-flop synchroniser with programmable reset level and one-cycle rise/fall strobes.
module sync_edge #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [N-1:0] sync_q;
  logic         prev_q;

  // Resetting every stage and the edge reference to the idle level keeps reset release edge-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {N{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
    end
  end

  assign rise_o = sync_q[N-1] & ~prev_q;
  assign fall_o = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/mic3_responder.sv
// ADC side of the MIC3 serial link: track-and-hold register plus a 16-bit SPI-style frame shifter.
module mic3_responder
  import mic3_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SCLK,
  input  logic                 CS,
  output logic                 MISO,
  input  logic [DATA_BITS-1:0] sample,
  input  logic                 sample_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_abort
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (SCLK),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (CS),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  state_e                  state_q, state_d;
  logic [DATA_BITS-1:0]    hold_q,  hold_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic                    miso_q,  miso_d;
  logic                    done_q,  done_d;
  logic                    abort_q, abort_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      miso_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      miso_q  <= miso_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    // The frame always copies hold_q (the old value), so a same-cycle load only affects later frames.
    hold_d  = sample_valid ? sample : hold_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    abort_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          shreg_d = build_frame(hold_q);
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // CS release wins over a coincident SCLK rise, which is then not counted.
        if (cs_rise) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_FULL) begin
            state_d = ST_TRAIL;
          end
        end else if (sclk_fall && (cnt_q != '0)) begin
          // The fall before the first rise only marks the start of bit 0.
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
        end
      end
      ST_TRAIL: begin
        if (cs_rise) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    miso_d = (state_d == ST_SHIFT) ? shreg_d[FRAME_BITS-1] : 1'b0;
  end

  assign MISO        = miso_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_mic3_responder.sv
// Scoreboard bench for mic3_responder: a 12.5 MHz SPI master collects MISO; a monitor checks each frame end.
module tb_mic3_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        SCLK;
  logic        CS;
  logic        MISO;
  logic [11:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        frame_done;
  logic        frame_abort;

  always #5 clk = ~clk;

  mic3_responder #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .SCLK         (SCLK),
    .CS           (CS),
    .MISO         (MISO),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort)
  );

  typedef struct {
    logic        is_done;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          n_done = 0;
  int          n_abort = 0;
  int          exp_done = 0;
  int          exp_abort = 0;
  logic [31:0] rx_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every frame-end pulse consumes one scoreboard entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (frame_done === 1'b1 || frame_abort === 1'b1) begin
      if (frame_done)  n_done++;
      if (frame_abort) n_abort++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, frame_done, frame_abort}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, frame_done, frame_abort}, e.is_done ? 32'd2 : 32'd1);
        check("rx_word", rx_word, e.word);
        check("busy_at_end", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [11:0] v);
    sample       = v;
    sample_valid = 1'b1;
    wait_clk(1);
    sample_valid = 1'b0;
    wait_clk(1);
  endtask

  // One master frame: n_rise SCLK cycles, MISO sampled as SCLK rises, then CS released.
  task automatic frame(input int n_rise, input logic [31:0] w, input logic is_done,
                       input int mid_at = 0, input logic [11:0] mid_val = 12'h000,
                       input logic pv_at_cs = 1'b0, input logic [11:0] pv_val = 12'h000);
    exp_q.push_back('{is_done, w});
    if (is_done) exp_done++;
    else         exp_abort++;
    rx_word = '0;
    CS = 1'b0;
    if (pv_at_cs) begin
      // Lands on the same clk edge as the synchronised cs_fall strobe.
      wait_clk(2);
      sample       = pv_val;
      sample_valid = 1'b1;
      wait_clk(1);
      sample_valid = 1'b0;
      wait_clk(1);
    end else begin
      wait_clk(4);
    end
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n_rise; i++) begin
      SCLK = 1'b0;
      wait_clk(4);
      SCLK = 1'b1;
      rx_word = {rx_word[30:0], MISO};
      if (i + 1 == mid_at) begin
        sample       = mid_val;
        sample_valid = 1'b1;
        wait_clk(1);
        sample_valid = 1'b0;
        wait_clk(3);
      end else begin
        wait_clk(4);
      end
    end
    CS = 1'b1;
    wait_clk(6);
    check("miso_idle", {31'd0, MISO}, 32'd0);
  endtask

  logic [11:0] tbl_in  [6] = '{12'h000, 12'hFFF, 12'h800, 12'h001, 12'h555, 12'hAAA};
  logic [15:0] tbl_exp [6] = '{16'h0000, 16'h1FFE, 16'h1000, 16'h0002, 16'h0AAA, 16'h1554};

  initial begin
    rst          = 1'b1;
    SCLK         = 1'b1;
    CS           = 1'b1;
    sample       = 12'h000;
    sample_valid = 1'b0;
    wait_clk(3);
    check("rst_miso",  {31'd0, MISO}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_pulses", {30'd0, frame_done, frame_abort}, 32'd0);
    check("rst_hold",  {20'd0, dut.hold_q}, 32'd0);
    rst = 1'b0;
    wait_clk(4);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Basic frame with 12'hA5C
    load(12'hA5C);
    frame(16, 32'h14B8, 1'b1);

    // Abort after 7 rises, then the same hold value is resent
    frame(7, 32'h0A, 1'b0);
    frame(16, 32'h14B8, 1'b1);

    // Mid-frame load does not disturb the frame in flight
    load(12'hFFF);
    frame(16, 32'h1FFE, 1'b1, 5, 12'h123);
    frame(16, 32'h0246, 1'b1);

    // Load coinciding with cs_fall: old value sent, new one kept
    load(12'h555);
    frame(16, 32'h0AAA, 1'b1, 0, 12'h000, 1'b1, 12'hAAA);
    frame(16, 32'h1554, 1'b1);

    // 20 SCLK edges: trailing bits read 0, counter saturates
    load(12'hA5C);
    frame(20, 32'h14B80, 1'b1);
    check("cnt_saturate", {27'd0, dut.cnt_q}, 32'd16);

    // Reset asserted at SCLK rise 9 abandons the frame silently
    load(12'h3C3);
    CS = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 9; i++) begin
      SCLK = 1'b0;
      wait_clk(4);
      SCLK = 1'b1;
      if (i < 8) wait_clk(4);
    end
    rst = 1'b1;
    wait_clk(2);
    check("midrst_miso", {31'd0, MISO}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_pulses", {30'd0, frame_done, frame_abort}, 32'd0);
    CS = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(8);
    check("after_rst_busy", {31'd0, busy}, 32'd0);
    check("after_rst_hold", {20'd0, dut.hold_q}, 32'd0);
    load(12'h001);
    frame(16, 32'h0002, 1'b1);

    // Directed value table
    for (int i = 0; i < 6; i++) begin
      load(tbl_in[i]);
      frame(16, {16'd0, tbl_exp[i]}, 1'b1);
    end

    wait_clk(10);
    check("done_count", n_done, exp_done);
    check("abort_count", n_abort, exp_abort);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mic3_responder.md
MIC3_RESPONDER -- requirements
Module: mic3_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchroniser flops on SCLK and CS (legal range 2..3).
REQ-002 SHALL have port clk, input, 1, system clock (100 MHz nominal); it is the only clock.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port SCLK, input, 1, SPI clock from the master; idle high.
REQ-005 SHALL have port CS, input, 1, chip select from the master, active-low.
REQ-006 SHALL have port MISO, output, 1, serial conversion data, MSB first.
REQ-007 SHALL have port sample, input, 12, next conversion value.
REQ-008 SHALL have port sample_valid, input, 1, loads sample into the hold register.
REQ-009 SHALL have port busy, output, 1, high while a frame is in progress (state not IDLE).
REQ-010 SHALL have port frame_done, output, 1, one-cycle pulse for a completed frame.
REQ-011 SHALL have port frame_abort, output, 1, one-cycle pulse when CS rises before 16 SCLK rising edges.

Function
REQ-012 SHALL emulate the ADC side of the MIC3 link: 16-bit frame, bit k is valid before SCLK rising edge k+1.
- Frame layout: k=0..2 are 0; k=3..14 are D11..D0; k=15 is 0.
REQ-013 SHALL pass SCLK and CS through SYNC_STAGES flops and derive one-cycle edge strobes from the synchronised copies.
- The strobes are sclk_fall, sclk_rise, cs_fall and cs_rise.
REQ-014 SHALL implement a 3-state FSM: IDLE, SHIFT and TRAIL.
REQ-015 In IDLE on cs_fall, SHALL copy the hold register into a 16-bit shift register and clear the edge counter.
- Shift register value: {3'b000, hold, 1'b0}.
- Next state: SHIFT.
- MISO = bit 15 in the same cycle the shift register loads.
REQ-016 In SHIFT, SHALL increment the 5-bit edge counter on each sclk_rise.
REQ-017 In SHIFT, SHALL shift left by one on each sclk_fall that follows at least one sclk_rise, with 0 shifted in; MISO = shift register MSB.
REQ-018 SHALL move from SHIFT to TRAIL when the edge counter reaches 16.
REQ-019 In TRAIL, SHALL hold MISO at 0 and ignore further SCLK edges; the counter saturates at 16.
REQ-020 On cs_rise in TRAIL, SHALL pulse frame_done and go to IDLE.
REQ-021 On cs_rise in SHIFT, SHALL pulse frame_abort and go to IDLE; the hold register is unchanged.
REQ-022 In IDLE, SHALL drive MISO to 0.
REQ-023 SHALL load the hold register on sample_valid in any state.
- A load during SHIFT or TRAIL does not affect the frame in flight (track-and-hold semantics).
REQ-024 If sample_valid and cs_fall occur in the same cycle, SHALL send the old hold value and store the new one.
REQ-025 If sclk_rise and cs_rise occur in the same cycle, SHALL give cs_rise priority and not count the edge.
REQ-026 SHALL operate correctly when SCLK high and low phases are each at least SYNC_STAGES+2 clk cycles (12.5 MHz at 100 MHz with SYNC_STAGES=2).
- Behaviour is unspecified for faster SCLK.

Reset
REQ-027 On rst, SHALL reset asynchronously to the following values:
- state = IDLE, MISO = 0, busy = 0, frame_done = 0, frame_abort = 0.
- hold register, shift register and edge counter = 0.
- Synchroniser flops: SCLK copy = 1, CS copy = 1 (no spurious edges on release).
REQ-028 Reset asserted mid-frame SHALL abandon the frame without a pulse.
- After release, a frame SHALL only start on a fresh cs_fall.

Structure
REQ-029 SHALL place FRAME_BITS=16, LEAD_ZEROS=3, DATA_BITS=12 and the state encoding in shared package mic3_pkg.
REQ-030 SHALL use one sub-module, sync_edge: an N-flop synchroniser with reset value and rise/fall strobe outputs, instantiated for SCLK and CS.

Verification
REQ-031 Load 12'hA5C, then run a 16-clock 12.5 MHz frame with a master model that samples on rising edges.
- Received bits: 000_1010_0101_1100_0.
- frame_done pulses exactly once; busy falls with it.
REQ-032 Raise CS after 7 rising edges -> frame_abort pulses once, frame_done stays 0; the next frame sends the same hold value.
REQ-033 Apply sample_valid with 12'h123 mid-frame while 12'hFFF is in flight -> current frame carries FFF, next frame carries 123.
REQ-034 Send 20 SCLK edges before CS rises -> edges 17..20 read 0, counter saturates at 16, one frame_done.
REQ-035 Assert rst at edge 9 -> MISO = 0, busy = 0, no pulses; a following full frame with 12'h001 is correct.
REQ-036 Pair with the existing mic3 receiver in loopback for 100 random samples -> audio equals each sample and new_data pulses once per frame.
